// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame size, FSM states and prescaler arithmetic.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  localparam int   UART_NDATA     = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // One bit period is prescaler+1 clocks.
  function automatic int prescaler(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate - 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..PRESCALER while run is high and pulses bit_end on the last clock.
// A restart or a low run input parks the counter at 0.
module uart_baud_gen #(
  parameter int PRESCALER = 276,
  parameter int NBITS     = 10
) (
  input  logic clk,
  input  logic nreset,
  input  logic run,
  input  logic restart,
  output logic bit_end
);

  localparam logic [NBITS-1:0] CNT_TOP = NBITS'(PRESCALER);

  logic [NBITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (restart || !run || (cnt_q == CNT_TOP)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_end = run && (cnt_q == CNT_TOP);

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter with an Avalon-ST byte sink and a one-entry holding register,
// so a byte offered mid-frame follows the current frame with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 32000000,
  parameter int baud_rate = 115200,
  parameter int NBITS     = 10
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       busy_o,
  output logic       tx
);

  localparam int PRESCALER = prescaler(clk_freq, baud_rate);

  // Handshake: a byte moves on a rising edge where tx_valid && tx_ready.
  // tx_ready comes straight from the hold-full register, never from tx_valid.

  uart_state_e state_q, state_d;
  logic [7:0]  shifter_q, shifter_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_q, tx_d;
  logic        xfer;
  logic        restart;
  logic        bit_end;
  logic        stop_end;

  assign tx_ready = ~hold_full_q;
  assign xfer     = tx_valid && tx_ready;
  assign busy_o   = (state_q != IDLE);
  assign tx       = tx_q;
  assign stop_end = (state_q == STOP) && bit_end;

  uart_baud_gen #(
    .PRESCALER(PRESCALER),
    .NBITS    (NBITS)
  ) u_baud_gen (
    .clk    (clk),
    .nreset (nreset),
    .run    (busy_o),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shifter_d   = shifter_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    restart     = 1'b0;
    tx_d        = UART_IDLE_LVL;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shifter_d = tx_data;
          state_d   = START;
          restart   = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'(UART_NDATA - 1)) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (hold_full_q) begin
            shifter_d   = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
          end else if (xfer) begin
            shifter_d = tx_data;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Mid-frame bytes park in hold unless the frame is ending and takes them directly.
    if (xfer && (state_q != IDLE) && !stop_end) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      START:   tx_d = UART_START_LVL;
      DATA:    tx_d = shifter_d[idx_d];
      STOP:    tx_d = UART_STOP_LVL;
      default: tx_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      shifter_q   <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= UART_IDLE_LVL;
    end else begin
      state_q     <= state_d;
      shifter_q   <= shifter_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (10-clock bit period) for protocol cases
// and a default-parameter instance for the 277-clock bit period.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       nreset;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       busy_o;
  logic       tx;

  logic       tx_valid_def;
  logic       tx_ready_def;
  logic [7:0] tx_data_def;
  logic       busy_def;
  logic       tx_def;

  int n_checks = 0;
  int n_errors = 0;
  int accepted = 0;
  logic [7:0] offer_q[$];

  always #5 clk = ~clk;

  uart_tx #(
    .clk_freq (1000000),
    .baud_rate(100000),
    .NBITS    (10)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .busy_o  (busy_o),
    .tx      (tx)
  );

  uart_tx dut_def (
    .clk     (clk),
    .nreset  (nreset),
    .tx_valid(tx_valid_def),
    .tx_ready(tx_ready_def),
    .tx_data (tx_data_def),
    .busy_o  (busy_def),
    .tx      (tx_def)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level at clock k of a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic frame_bit(input logic [7:0] d, input int k, input int period);
    int b;
    b = k / period;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic drive();
    if (offer_q.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = offer_q[0];
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic offer(input logic [7:0] b);
    offer_q.push_back(b);
    drive();
  endtask

  // Advance one clock; inputs and outputs are handled at the falling edge.
  task automatic step();
    logic       hs;
    logic [7:0] dropped;
    hs = tx_valid && tx_ready;
    @(negedge clk);
    if (hs) begin
      dropped = offer_q.pop_front();
      accepted++;
    end
    drive();
  endtask

  task automatic check_bits(input string tag, input logic [7:0] d, input int k_from,
                            input int k_to, input int rdy_lo_first, input int rdy_lo_last);
    for (int k = k_from; k <= k_to; k++) begin
      check($sformatf("%s_tx@%0d", tag, k), tx, frame_bit(d, k, 10));
      check($sformatf("%s_busy@%0d", tag, k), busy_o, 1);
      check($sformatf("%s_rdy@%0d", tag, k), tx_ready,
            (k >= rdy_lo_first && k <= rdy_lo_last) ? 0 : 1);
      step();
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_tx@%0d", tag, k), tx, 1);
      check($sformatf("%s_busy@%0d", tag, k), busy_o, 0);
      check($sformatf("%s_rdy@%0d", tag, k), tx_ready, 1);
      step();
    end
  endtask

  initial begin
    nreset       = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    tx_valid_def = 1'b0;
    tx_data_def  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_rdy", tx_ready, 1);
    check("rst_busy", busy_o, 0);
    check("rst_def_tx", tx_def, 1);
    check("rst_def_rdy", tx_ready_def, 1);
    check("rst_def_busy", busy_def, 0);
    nreset = 1'b1;
    check_idle("idle0", 3);

    // Single byte from idle; start bit one clock after the handshake.
    offer(8'h55);
    check("t1_rdy_pre", tx_ready, 1);
    step();
    check_bits("t1", 8'h55, 0, 99, -1, -1);
    check_idle("t1_end", 5);

    // Back-to-back: second byte parks in hold until frame 1 ends.
    offer(8'hA5);
    offer(8'h3C);
    step();
    check_bits("t2a", 8'hA5, 0, 99, 1, 99);
    check_bits("t2b", 8'h3C, 0, 99, -1, -1);
    check_idle("t2_end", 3);

    // Third byte waits for tx_ready and is accepted exactly once.
    accepted = 0;
    offer(8'h11);
    offer(8'h22);
    offer(8'h33);
    step();
    check_bits("t3a", 8'h11, 0, 99, 1, 99);
    check_bits("t3b", 8'h22, 0, 99, 1, 99);
    check_bits("t3c", 8'h33, 0, 99, -1, -1);
    check("t3_accepted", 32'(accepted), 3);
    check("t3_pending", 32'(offer_q.size()), 0);
    check_idle("t3_end", 5);

    // Handshake on the last clock of STOP with hold empty: no idle gap.
    offer(8'h77);
    step();
    check_bits("t4a", 8'h77, 0, 98, -1, -1);
    offer(8'h00);
    check_bits("t4a", 8'h77, 99, 99, -1, -1);
    check_bits("t4b", 8'h00, 0, 99, -1, -1);
    check_idle("t4_end", 3);

    // Reset mid-frame discards both the in-flight and the held byte.
    offer(8'hFF);
    offer(8'hEE);
    step();
    check_bits("t5a", 8'hFF, 0, 34, 1, 34);
    nreset = 1'b0;
    #1;
    check("t5_rst_tx", tx, 1);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_rdy", tx_ready, 1);
    @(negedge clk);
    nreset = 1'b1;
    check_idle("t5_post", 5);
    offer(8'h81);
    step();
    check_bits("t5b", 8'h81, 0, 99, -1, -1);
    check_idle("t5_end", 3);

    // Default parameters: 277 clocks per bit, 2770 per frame.
    tx_valid_def = 1'b1;
    tx_data_def  = 8'hC3;
    check("t6_rdy_pre", tx_ready_def, 1);
    @(negedge clk);
    tx_valid_def = 1'b0;
    for (int k = 0; k < 2770; k++) begin
      check($sformatf("t6_tx@%0d", k), tx_def, frame_bit(8'hC3, k, 277));
      check($sformatf("t6_busy@%0d", k), busy_def, 1);
      @(negedge clk);
    end
    check("t6_end_tx", tx_def, 1);
    check("t6_end_busy", busy_def, 0);
    check("t6_end_rdy", tx_ready_def, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
